// File: rtl/star_demux_pkg.sv
// Shared encodings for the star ring: route codes, demux FSM states and the
// broadcast address helper.
package star_demux_pkg;

    // Where the current packet goes.
    typedef enum logic [1:0] {
        ROUTE_LOC  = 2'd0,
        ROUTE_FWD  = 2'd1,
        ROUTE_BOTH = 2'd2
    } route_e;

    // Demux FSM: IDLE decodes headers, PKT_* hold the locked route until TLAST.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PKT_LOC  = 2'd1,
        PKT_FWD  = 2'd2,
        PKT_BOTH = 2'd3
    } state_e;

    // All-ones address of a destination field of the given width.
    function automatic logic [63:0] bcast_addr(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    // State entered when a multi-flit packet starts on the given route.
    function automatic state_e route_to_state(input route_e route);
        case (route)
            ROUTE_LOC:  return PKT_LOC;
            ROUTE_BOTH: return PKT_BOTH;
            default:    return PKT_FWD;
        endcase
    endfunction

endpackage

// File: rtl/star_demux_bhand.sv
// Single-stage registered handshake buffer. The output valid comes straight
// from a flop, so it never depends combinationally on odata_rdy; the stage
// refills in the same cycle it drains, giving one flit per cycle.
module star_demux_bhand #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] idata,
    input  logic             idata_vld,
    output logic             idata_rdy,
    output logic [WIDTH-1:0] odata,
    output logic             odata_vld,
    input  logic             odata_rdy
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    assign idata_rdy = !vld_q || odata_rdy;
    assign odata     = data_q;
    assign odata_vld = vld_q;

    // Load a new flit whenever the stage is empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset too because the outputs must read
            // zero while in reset; a plain pipeline register would not need it.
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (idata_rdy) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            vld_q <= idata_vld;
            if (idata_vld) begin
                data_q <= idata;
            end
        end
    end

endmodule

// File: rtl/star_demux.sv
// Receive-side packet demultiplexer for the star-arbiter ring. The header flit's
// destination field picks local delivery, forwarding, or both (broadcast); the
// choice is held until TLAST. Each output is registered through its own buffer.
module star_demux
    import star_demux_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH    = 64,
    parameter int unsigned            DEST_LSB      = 0,
    parameter int unsigned            DEST_WIDTH    = 8,
    parameter logic [DEST_WIDTH-1:0]  MY_ADDR       = '0,
    parameter int unsigned            PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_TDATA,
    input  logic                     in_TVALID,
    input  logic                     in_TLAST,
    output logic                     in_TREADY,
    output logic [DATA_WIDTH-1:0]    loc_TDATA,
    output logic                     loc_TVALID,
    output logic                     loc_TLAST,
    input  logic                     loc_TREADY,
    output logic [DATA_WIDTH-1:0]    nxt_TDATA,
    output logic                     nxt_TVALID,
    output logic                     nxt_TLAST,
    input  logic                     nxt_TREADY,
    output logic [PKT_CNT_WIDTH-1:0] loc_pkts,
    output logic [PKT_CNT_WIDTH-1:0] fwd_pkts
);

    localparam logic [DEST_WIDTH-1:0] BCAST = DEST_WIDTH'(bcast_addr(DEST_WIDTH));

    state_e                state_q;
    state_e                state_d;
    route_e                hdr_route;
    route_e                route;
    logic [DEST_WIDTH-1:0] dest;
    logic                  accept;
    logic                  route_loc;
    logic                  route_fwd;
    logic                  loc_vld;
    logic                  loc_rdy;
    logic                  nxt_vld;
    logic                  nxt_rdy;
    logic                  ready;
    logic [DATA_WIDTH:0]   flit;
    logic [DATA_WIDTH:0]   loc_flit;
    logic [DATA_WIDTH:0]   nxt_flit;

    assign dest   = in_TDATA[DEST_LSB +: DEST_WIDTH];
    assign flit   = {in_TLAST, in_TDATA};
    // Nothing is accepted while reset is held.
    assign in_TREADY = ready && rst;
    assign accept    = in_TVALID && in_TREADY;

    // Decode the destination field as if the current flit were a header.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        hdr_route = ROUTE_FWD;
        if (dest == MY_ADDR) begin
            hdr_route = ROUTE_LOC;
        end else if (dest == BCAST) begin
            hdr_route = ROUTE_BOTH;
        end
    end

    // Effective route: live decode in IDLE, locked route inside a packet.
    always_comb begin
        route = hdr_route;
        case (state_q)
            PKT_LOC:  route = ROUTE_LOC;
            PKT_FWD:  route = ROUTE_FWD;
            PKT_BOTH: route = ROUTE_BOTH;
            default:  route = hdr_route;
        endcase
    end

    assign route_loc = (route == ROUTE_LOC) || (route == ROUTE_BOTH);
    assign route_fwd = (route == ROUTE_FWD) || (route == ROUTE_BOTH);

    // Steer the input handshake; a broadcast flit is written to both buffers
    // in the same cycle or to neither.
    always_comb begin
        loc_vld = 1'b0;
        nxt_vld = 1'b0;
        ready   = 1'b0;
        case (route)
            ROUTE_LOC: begin
                loc_vld = in_TVALID;
                ready   = loc_rdy;
            end
            ROUTE_FWD: begin
                nxt_vld = in_TVALID;
                ready   = nxt_rdy;
            end
            default: begin
                loc_vld = in_TVALID && nxt_rdy;
                nxt_vld = in_TVALID && loc_rdy;
                ready   = loc_rdy && nxt_rdy;
            end
        endcase
    end

    // Next state: open a packet on a non-final header, close it on TLAST.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (state_q == IDLE) begin
                if (!in_TLAST) begin
                    state_d = route_to_state(hdr_route);
                end
            end else if (in_TLAST) begin
                state_d = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Count packets whose final flit was accepted toward each output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loc_pkts <= '0;
            fwd_pkts <= '0;
        end else if (accept && in_TLAST) begin
            if (route_loc) begin
                loc_pkts <= loc_pkts + PKT_CNT_WIDTH'(1);
            end
            if (route_fwd) begin
                fwd_pkts <= fwd_pkts + PKT_CNT_WIDTH'(1);
            end
        end
    end

    star_demux_bhand #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_loc_buf (
        .clk       (clk),
        .rst       (rst),
        .idata     (flit),
        .idata_vld (loc_vld),
        .idata_rdy (loc_rdy),
        .odata     (loc_flit),
        .odata_vld (loc_TVALID),
        .odata_rdy (loc_TREADY)
    );

    star_demux_bhand #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_nxt_buf (
        .clk       (clk),
        .rst       (rst),
        .idata     (flit),
        .idata_vld (nxt_vld),
        .idata_rdy (nxt_rdy),
        .odata     (nxt_flit),
        .odata_vld (nxt_TVALID),
        .odata_rdy (nxt_TREADY)
    );

    assign {loc_TLAST, loc_TDATA} = loc_flit;
    assign {nxt_TLAST, nxt_TDATA} = nxt_flit;

endmodule

// File: tb/tb_star_demux.sv
// Directed bench for star_demux with MY_ADDR=5. The driver pushes the expected
// flit into per-output queues when the DUT accepts it; a monitor pops and
// compares whenever an output completes a transfer.
module tb_star_demux;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_TDATA;
    logic          in_TVALID;
    logic          in_TLAST;
    logic          in_TREADY;
    logic [DW-1:0] loc_TDATA;
    logic          loc_TVALID;
    logic          loc_TLAST;
    logic          loc_TREADY;
    logic [DW-1:0] nxt_TDATA;
    logic          nxt_TVALID;
    logic          nxt_TLAST;
    logic          nxt_TREADY;
    logic [CW-1:0] loc_pkts;
    logic [CW-1:0] fwd_pkts;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW:0] loc_q[$];
    logic [DW:0] nxt_q[$];

    always #5 clk = ~clk;

    star_demux #(
        .DATA_WIDTH    (DW),
        .DEST_LSB      (0),
        .DEST_WIDTH    (8),
        .MY_ADDR       (8'd5),
        .PKT_CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TLAST   (in_TLAST),
        .in_TREADY  (in_TREADY),
        .loc_TDATA  (loc_TDATA),
        .loc_TVALID (loc_TVALID),
        .loc_TLAST  (loc_TLAST),
        .loc_TREADY (loc_TREADY),
        .nxt_TDATA  (nxt_TDATA),
        .nxt_TVALID (nxt_TVALID),
        .nxt_TLAST  (nxt_TLAST),
        .nxt_TREADY (nxt_TREADY),
        .loc_pkts   (loc_pkts),
        .fwd_pkts   (fwd_pkts)
    );

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and ready
    // are both high at the falling edge (inputs only change just after posedge).
    always @(negedge clk) begin
        if (rst) begin
            if (loc_TVALID && loc_TREADY) begin
                if (loc_q.size() == 0) begin
                    check("loc_unexpected", {loc_TLAST, loc_TDATA}, '1);
                end else begin
                    check("loc_flit", {loc_TLAST, loc_TDATA}, loc_q.pop_front());
                end
            end
            if (nxt_TVALID && nxt_TREADY) begin
                if (nxt_q.size() == 0) begin
                    check("nxt_unexpected", {nxt_TLAST, nxt_TDATA}, '1);
                end else begin
                    check("nxt_flit", {nxt_TLAST, nxt_TDATA}, nxt_q.pop_front());
                end
            end
        end
    end

    // Offer one flit; record where it must appear once accepted. Returns at
    // 1 time unit after the accepting edge with the number of stalled cycles.
    task automatic send(input logic [DW-1:0] data, input logic last,
                        input bit to_loc, input bit to_nxt, output int stalls);
        bit acc;
        acc       = 1'b0;
        stalls    = 0;
        in_TDATA  = data;
        in_TLAST  = last;
        in_TVALID = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_TREADY) begin
                acc = 1'b1;
                if (to_loc) loc_q.push_back({last, data});
                if (to_nxt) nxt_q.push_back({last, data});
            end
            @(posedge clk);
            #1;
            if (!acc) stalls++;
        end
        in_TVALID = 1'b0;
        check("send_accepted", {64'd0, acc}, 65'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        in_TDATA   = '0;
        in_TVALID  = 1'b0;
        in_TLAST   = 1'b0;
        loc_TREADY = 1'b1;
        nxt_TREADY = 1'b1;

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_loc_vld",  loc_TVALID, 0);
        check("rst_nxt_vld",  nxt_TVALID, 0);
        check("rst_loc_data", {loc_TLAST, loc_TDATA}, 0);
        check("rst_nxt_data", {nxt_TLAST, nxt_TDATA}, 0);
        check("rst_in_rdy",   in_TREADY, 0);
        check("rst_loc_pkts", loc_pkts, 0);
        check("rst_fwd_pkts", fwd_pkts, 0);
        rst = 1'b1;

        // 3-flit packet to this node, one cycle latency
        send(64'h1105, 1'b0, 1, 0, st);
        check("t1_lat_vld",  loc_TVALID, 1);
        check("t1_lat_data", loc_TDATA, 64'h1105);
        send(64'h22, 1'b0, 1, 0, st);
        send(64'h33, 1'b1, 1, 0, st);
        check("t1_loc_pkts", loc_pkts, 1);
        check("t1_fwd_pkts", fwd_pkts, 0);

        // Back-to-back single-flit packets: forward, then local
        send(64'h07, 1'b1, 0, 1, st);
        check("t2_nxt_vld", nxt_TVALID, 1);
        send(64'h05, 1'b1, 1, 0, st);
        check("t2_no_bubble", st, 0);
        check("t2_loc_vld", loc_TVALID, 1);
        check("t2_fwd_pkts", fwd_pkts, 1);
        check("t2_loc_pkts", loc_pkts, 2);

        // Idle with TVALID low: toggling TDATA must not open a packet
        in_TDATA = 64'h05; @(posedge clk); #1;
        in_TDATA = 64'hFF; @(posedge clk); #1;
        in_TDATA = 64'h07; @(posedge clk); #1;
        check("idle_fwd_pkts", fwd_pkts, 1);
        check("idle_loc_pkts", loc_pkts, 2);

        // Broadcast with a 3-cycle stall on the forward output
        send(64'hAB_FF, 1'b0, 1, 1, st);
        send(64'h01, 1'b0, 1, 1, st);
        nxt_TREADY = 1'b0;
        @(negedge clk);
        check("t3_in_rdy_stall", in_TREADY, 0);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 nxt_TREADY = 1'b1;
            end
        join_none
        send(64'h02, 1'b0, 1, 1, st);
        check("t3_stall_cycles", st, 3);
        send(64'h03, 1'b1, 1, 1, st);
        check("t3_loc_pkts", loc_pkts, 3);
        check("t3_fwd_pkts", fwd_pkts, 2);

        // Route locked: body flits carrying 0x09 still go local
        send(64'h05, 1'b0, 1, 0, st);
        send(64'h09, 1'b0, 1, 0, st);
        send(64'h0909, 1'b1, 1, 0, st);
        check("t4_loc_pkts", loc_pkts, 4);
        check("t4_fwd_pkts", fwd_pkts, 2);

        // Reset mid-packet: second flit is lost, counters clear
        send(64'h09, 1'b0, 0, 1, st);
        send(64'hA0, 1'b0, 0, 0, st);
        rst = 1'b0;
        #1;
        check("t5_nxt_vld",   nxt_TVALID, 0);
        check("t5_in_rdy",    in_TREADY, 0);
        check("t5_loc_pkts",  loc_pkts, 0);
        check("t5_fwd_pkts",  fwd_pkts, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send(64'h05, 1'b1, 1, 0, st);
        check("t5_post_loc_pkts", loc_pkts, 1);
        check("t5_post_fwd_pkts", fwd_pkts, 0);

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            send(64'h07, 1'b1, 0, 1, st);
        end
        check("t6_fwd_full", fwd_pkts, 16'hFFFF);
        send(64'h07, 1'b1, 0, 1, st);
        check("t6_fwd_wrap", fwd_pkts, 0);
        check("t6_loc_pkts", loc_pkts, 1);

        // Everything expected has been delivered
        repeat (5) @(posedge clk);
        #1;
        check("drain_loc", loc_q.size(), 0);
        check("drain_nxt", nxt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
